// File: rtl/c_split2_cache.sv
// rtl/c_split2_cache.sv - clocked two-way token split for the cache control path
//
// Takes one drive/free token at a time from a single upstream sender. It
// routes each token to branch 0 or branch 1 using bit SEL_BIT of the token
// data, then holds it on that branch until the consumer returns free.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_drive, i_data           upstream token pulse and its data
//   o_free                    pulse: input slot released, upstream may drive again
//   o_driveNext0/1, o_data0/1 per-branch token pulse and held data
//   i_freeNext0/1             per-branch consumer release pulse
//   o_cnt0/1                  per-branch delivered-token counters (wrapping)
//   o_err                     sticky flags: [0] overrun, [1]/[2] spurious free 0/1
module c_split2_cache #(
    parameter int DATA_WIDTH = 5,
    parameter int SEL_BIT    = DATA_WIDTH - 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_drive,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_free,
    output logic                  o_driveNext0,
    output logic                  o_driveNext1,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    input  logic                  i_freeNext0,
    input  logic                  i_freeNext1,
    output logic [CNT_WIDTH-1:0]  o_cnt0,
    output logic [CNT_WIDTH-1:0]  o_cnt1,
    output logic [2:0]            o_err
);

    logic                  in_valid_q, in_valid_d;
    logic [DATA_WIDTH-1:0] in_reg_q,   in_reg_d;
    logic                  busy0_q,    busy0_d;
    logic                  busy1_q,    busy1_d;
    logic [DATA_WIDTH-1:0] data0_q,    data0_d;
    logic [DATA_WIDTH-1:0] data1_q,    data1_d;
    logic [CNT_WIDTH-1:0]  cnt0_q,     cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q,     cnt1_d;
    logic [2:0]            err_q,      err_d;
    logic                  free_q,     free_d;
    logic                  drive0_q,   drive0_d;
    logic                  drive1_q,   drive1_d;

    logic sel;
    logic ready0, ready1;
    logic xfer0,  xfer1;

    always_comb begin
        sel = in_reg_q[SEL_BIT];

        // A busy branch still accepts a refill on the edge its consumer frees it.
        ready0 = !busy0_q || i_freeNext0;
        ready1 = !busy1_q || i_freeNext1;

        // The held token only ever goes to its own branch: no bypass, no reorder.
        xfer0 = in_valid_q && !sel && ready0;
        xfer1 = in_valid_q &&  sel && ready1;

        in_valid_d = in_valid_q;
        in_reg_d   = in_reg_q;
        if (xfer0 || xfer1) begin
            in_valid_d = 1'b0;
        end
        // Capture only from EMPTY; a drive while FULL (even on the transfer
        // cycle) is an overrun and leaves in_reg untouched.
        if (!in_valid_q && i_drive) begin
            in_valid_d = 1'b1;
            in_reg_d   = i_data;
        end

        // Refill wins over free on the same edge, so busy stays set.
        busy0_d = busy0_q;
        if (i_freeNext0) busy0_d = 1'b0;
        if (xfer0)       busy0_d = 1'b1;
        busy1_d = busy1_q;
        if (i_freeNext1) busy1_d = 1'b0;
        if (xfer1)       busy1_d = 1'b1;

        data0_d = xfer0 ? in_reg_q : data0_q;
        data1_d = xfer1 ? in_reg_q : data1_q;

        cnt0_d = cnt0_q + {{(CNT_WIDTH-1){1'b0}}, xfer0};
        cnt1_d = cnt1_q + {{(CNT_WIDTH-1){1'b0}}, xfer1};

        err_d = err_q | {i_freeNext1 && !busy1_q,
                         i_freeNext0 && !busy0_q,
                         i_drive     &&  in_valid_q};

        free_d   = xfer0 || xfer1;
        drive0_d = xfer0;
        drive1_d = xfer1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_valid_q <= 1'b0;
            in_reg_q   <= '0;
            busy0_q    <= 1'b0;
            busy1_q    <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            err_q      <= '0;
            free_q     <= 1'b0;
            drive0_q   <= 1'b0;
            drive1_q   <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
            in_reg_q   <= in_reg_d;
            busy0_q    <= busy0_d;
            busy1_q    <= busy1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            err_q      <= err_d;
            free_q     <= free_d;
            drive0_q   <= drive0_d;
            drive1_q   <= drive1_d;
        end
    end

    assign o_free       = free_q;
    assign o_driveNext0 = drive0_q;
    assign o_driveNext1 = drive1_q;
    assign o_data0      = data0_q;
    assign o_data1      = data1_q;
    assign o_cnt0       = cnt0_q;
    assign o_cnt1       = cnt1_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_c_split2_cache.sv
// tb/tb_c_split2_cache.sv - scoreboard testbench for c_split2_cache
module tb_c_split2_cache;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_drive;
    logic [4:0] i_data;
    logic       o_free;
    logic       o_driveNext0;
    logic       o_driveNext1;
    logic [4:0] o_data0;
    logic [4:0] o_data1;
    logic       i_freeNext0;
    logic       i_freeNext1;
    logic [7:0] o_cnt0;
    logic [7:0] o_cnt1;
    logic [2:0] o_err;

    c_split2_cache #(.DATA_WIDTH(5), .SEL_BIT(4), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_drive      (i_drive),
        .i_data       (i_data),
        .o_free       (o_free),
        .o_driveNext0 (o_driveNext0),
        .o_driveNext1 (o_driveNext1),
        .o_data0      (o_data0),
        .o_data1      (o_data1),
        .i_freeNext0  (i_freeNext0),
        .i_freeNext1  (i_freeNext1),
        .o_cnt0       (o_cnt0),
        .o_cnt1       (o_cnt1),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected tokens per branch, in issue order.
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    // Written only by the monitor.
    logic [7:0] exp_cnt0 = 8'd0;
    logic [7:0] exp_cnt1 = 8'd0;
    int deliv0 = 0, deliv1 = 0, free_seen = 0;

    // Written only by the stimulus process.
    int issued = 0, freed0 = 0, freed1 = 0;
    bit arm0 = 0, arm1 = 0;
    int w0 = 0, w1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {o_free, o_driveNext0, o_driveNext1, o_data0, o_data1, o_cnt0, o_cnt1, o_err};
    endfunction

    // Monitor: pops the scoreboard whenever a branch presents a token.
    initial begin : monitor
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                q0.delete();
                q1.delete();
                exp_cnt0 = 8'd0;
                exp_cnt1 = 8'd0;
            end else begin
                if (o_driveNext0) begin
                    if (q0.size() == 0) check("dn0_unexpected", 32'd1, 32'd0);
                    else begin
                        e = q0.pop_front();
                        check("data0", {27'd0, o_data0}, {27'd0, e});
                    end
                    exp_cnt0 = exp_cnt0 + 8'd1;
                    check("cnt0", {24'd0, o_cnt0}, {24'd0, exp_cnt0});
                    deliv0++;
                end
                if (o_driveNext1) begin
                    if (q1.size() == 0) check("dn1_unexpected", 32'd1, 32'd0);
                    else begin
                        e = q1.pop_front();
                        check("data1", {27'd0, o_data1}, {27'd0, e});
                    end
                    exp_cnt1 = exp_cnt1 + 8'd1;
                    check("cnt1", {24'd0, o_cnt1}, {24'd0, exp_cnt1});
                    deliv1++;
                end
                if (o_free || o_driveNext0 || o_driveNext1) begin
                    check("free_pulse", {31'd0, o_free}, 32'd1);
                    check("one_branch", {30'd0, o_driveNext0, o_driveNext1} == 32'd1 ||
                                        {30'd0, o_driveNext0, o_driveNext1} == 32'd2 ? 32'd1 : 32'd0, 32'd1);
                end
                if (o_free) free_seen++;
            end
        end
    end

    // One cycle: apply inputs after the edge, return just after mid-cycle.
    task automatic cyc(input logic d, input logic [4:0] dat, input logic f0, input logic f1, input logic p);
        @(posedge clk); #1;
        i_drive = d; i_data = dat; i_freeNext0 = f0; i_freeNext1 = f1;
        if (p) begin
            if (dat[4]) q1.push_back(dat);
            else        q0.push_back(dat);
        end
        @(negedge clk); #1;
    endtask

    task automatic resync();
        issued = free_seen; freed0 = deliv0; freed1 = deliv1;
        arm0 = 0; arm1 = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; i_drive = 0; i_data = 0; i_freeNext0 = 0; i_freeNext1 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        resync();
    endtask

    // Random upstream plus consumers that free each held token after 0..3 cycles.
    task automatic run(input int n, input bit en_drive);
        logic f0, f1, d;
        logic [4:0] dat;
        for (int c = 0; c < n; c++) begin
            f0 = 0; f1 = 0;
            if (deliv0 != freed0) begin
                if (!arm0) begin arm0 = 1; w0 = $urandom_range(0, 3); end
                if (w0 == 0) begin f0 = 1; freed0++; arm0 = 0; end
                else w0--;
            end
            if (deliv1 != freed1) begin
                if (!arm1) begin arm1 = 1; w1 = $urandom_range(0, 3); end
                if (w1 == 0) begin f1 = 1; freed1++; arm1 = 0; end
                else w1--;
            end
            d   = en_drive && (issued == free_seen) && ($urandom_range(0, 1) == 1);
            dat = 5'($urandom);
            if (d) issued++;
            cyc(d, dat, f0, f1, d);
        end
    endtask

    initial begin : stim
        rstn = 1'b0; i_drive = 0; i_data = 0; i_freeNext0 = 0; i_freeNext1 = 0;
        do_reset();

        // Single token to idle branch 0: two-cycle latency.
        cyc(1, 5'h03, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("t1_not_early", {31'd0, o_driveNext0}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("t1_dn0", {31'd0, o_driveNext0}, 32'd1);
        check("t1_free", {31'd0, o_free}, 32'd1);
        check("t1_data0", {27'd0, o_data0}, 32'h03);
        check("t1_cnt0", {24'd0, o_cnt0}, 32'd1);
        check("t1_dn1", {31'd0, o_driveNext1}, 32'd0);
        cyc(0, 0, 1, 0, 0);

        // Head-of-line block on busy branch 1.
        cyc(1, 5'h12, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_dn1_first", {31'd0, o_driveNext1}, 32'd1);
        cyc(1, 5'h15, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("t2_blocked_dn1", {31'd0, o_driveNext1}, 32'd0);
        check("t2_blocked_free", {31'd0, o_free}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("t2_dn1", {31'd0, o_driveNext1}, 32'd1);
        check("t2_data1", {27'd0, o_data1}, 32'h15);
        check("t2_free", {31'd0, o_free}, 32'd1);
        cyc(0, 0, 0, 1, 0);

        // Free-and-refill of branch 0 on one edge.
        cyc(1, 5'h01, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 5'h02, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        check("t3_wait", {31'd0, o_driveNext0}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("t3_dn0", {31'd0, o_driveNext0}, 32'd1);
        check("t3_data0", {27'd0, o_data0}, 32'h02);
        check("t3_cnt0", {24'd0, o_cnt0}, 32'd3);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t3_err", {29'd0, o_err}, 32'd0);

        // Overrun: second drive before o_free is dropped.
        do_reset();
        cyc(1, 5'h0A, 0, 0, 1);
        cyc(1, 5'h0B, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t4_err", {29'd0, o_err}, 32'd1);
        check("t4_data0", {27'd0, o_data0}, 32'h0A);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t4_no_second_a", {31'd0, o_driveNext0}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("t4_no_second_b", {31'd0, o_driveNext0}, 32'd0);
        check("t4_cnt0", {24'd0, o_cnt0}, 32'd1);

        // Spurious free on idle branch 1.
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("t5_err", {29'd0, o_err}, 32'd4);
        cyc(1, 5'h11, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t5_dn1", {31'd0, o_driveNext1}, 32'd1);
        check("t5_data1", {27'd0, o_data1}, 32'h11);
        check("t5_err_kept", {29'd0, o_err}, 32'd4);
        cyc(0, 0, 0, 1, 0);

        // 256 branch-0 tokens: counter wraps to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cyc(1, {1'b0, 4'($urandom)}, (i > 0), 0, 1);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t6_cnt0_wrap", {24'd0, o_cnt0}, 32'd0);
        check("t6_cnt1", {24'd0, o_cnt1}, 32'd0);
        check("t6_err", {29'd0, o_err}, 32'd0);

        // Random traffic, asynchronous reset mid-stream, more traffic, drain.
        do_reset();
        run(1500, 1);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("async_reset", all_outs(), 32'd0);
        i_drive = 0; i_freeNext0 = 0; i_freeNext1 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", all_outs(), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        resync();
        run(800, 1);
        run(40, 0);
        check("drain_empty", q0.size() + q1.size(), 32'd0);
        check("random_err", {29'd0, o_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
